mini_mips_main_control: RTL and testbench
=========================================

// Module: mini_mips_main_control
// PURPOSE
//  Multi-cycle MiniMips main control FSM: sequences fetch/decode/execute/memory/writeback per instruction.
//  Drives datapath enables and the 3-bit ALUop (ALUop2..0) consumed by the ALU-control bit generators.
//  Stalls on a memory ready handshake; a watchdog flags memory timeouts.
// PARAMETERS
//  OPCODE_W     4   opcode width (instr[15:12])
//  MEM_TMO      15  max wait cycles for mem_ready before bus_error
// PORTS
//  clk          in   1  system clock, rising edge
//  reset        in   1  synchronous, active-high
//  Opcode       in   4  IR opcode field (valid from DECODE on)
//  Zero         in   1  ALU zero flag
//  mem_ready    in   1  memory completes current access this cycle
//  mem_req      out  1  memory access request (asserted with MemRead or MemWrite)
//  MemRead/MemWrite/IRWrite/IorD/PCWrite/PCWriteCond/RegWrite/RegDst/MemtoReg/ALUSrcA  out 1 each
//  ALUSrcB      out  2  00 reg B, 01 const 1, 10 sign-ext imm, 11 shifted imm
//  PCSource     out  2  00 ALU result, 01 ALUOut, 10 jump target
//  ALUop2..0    out  1 each  000 add, 001 sub, 010 and, 011 or, 111 R-type (func decides)
//  illegal_op   out  1  one-cycle pulse on undefined opcode
//  bus_error    out  1  sticky until reset; memory timeout
// BEHAVIOUR
//  Reset: state=FETCH, wait counter=0, all outputs 0 (ALUop=000) in the reset cycle; bus_error cleared.
//  Opcodes: 0 R-type, 1 addi, 2 andi, 3 ori, 4 lw, 5 sw, 6 beq, 7 bne, 8 j; 9-15 illegal.
//  States/transitions (outputs Moore, decoded from state only; Zero used for PCWriteCond):
//   FETCH: mem_req,MemRead,IorD=0,ALUSrcA=0,ALUSrcB=01,ALUop=000; on mem_ready: IRWrite,PCWrite -> DECODE; else hold.
//   DECODE: ALUSrcB=11,ALUop=000 (branch target); R->EXEC_R, 1-3->EXEC_I, 4/5->MEM_ADDR, 6/7->BRANCH, 8->JUMP, else illegal_op -> FETCH.
//   EXEC_R: ALUSrcA=1,ALUSrcB=00,ALUop=111 -> WB_R (RegWrite,RegDst=1,MemtoReg=0) -> FETCH.
//   EXEC_I: ALUSrcA=1,ALUSrcB=10,ALUop=000/010/011 for 1/2/3 -> WB_I (RegWrite,RegDst=0) -> FETCH.
//   MEM_ADDR: ALUSrcA=1,ALUSrcB=10,ALUop=000 -> MEM_RD (lw) or MEM_WR (sw).
//   MEM_RD: mem_req,MemRead,IorD=1; hold until mem_ready -> MEM_WB (RegWrite,MemtoReg=1,RegDst=0) -> FETCH.
//   MEM_WR: mem_req,MemWrite,IorD=1; hold until mem_ready -> FETCH.
//   BRANCH: ALUSrcA=1,ALUSrcB=00,ALUop=001,PCSource=01; PCWriteCond=1; PC loads iff Zero (beq) / !Zero (bne) -> FETCH.
//   JUMP: PCWrite,PCSource=10 -> FETCH.
//  Latency: R/I-type 4 cycles, lw 5, sw 4, branch/jump 3 (mem_ready=1 every access).
//  Wait counter: increments each cycle mem_req=1 and mem_ready=0; clears on mem_ready or state change.
//   Reaching MEM_TMO: set bus_error, drop request, -> FETCH (no IRWrite/RegWrite/PCWrite). Counter saturates, never wraps.
//  mem_ready while mem_req=0: ignored. Opcode only sampled in DECODE; changes elsewhere have no effect.
//  reset mid-instruction: next cycle FETCH, no pending write completes.
//  bne uses PCWriteCond with inverted Zero internally; single PCWriteCond port.
// STRUCTURE
//  Shared package mini_mips_pkg: opcode constants, ALUop encodings, state enum, ALUSrcB/PCSource codes.
//  One sub-module natural: mini_mips_mem_watchdog (counter + bus_error).
//  Output decode as one combinational case on state; next-state in separate case.
// TESTING
//  reset held 2 cycles, then released -> state FETCH, MemRead=1, ALUop=000, bus_error=0.
//  Opcode=0, mem_ready=1 always -> ALUop=111 only in EXEC_R, RegWrite=1 in cycle 4, back to FETCH cycle 5.
//  Opcode=4, mem_ready low 3 cycles in MEM_RD -> holds MEM_RD, MemRead stays 1, MemtoReg/RegWrite one cycle after ready.
//  Opcode=6 with Zero=1 then Zero=0 -> ALUop=001, PC loads only first case; Opcode=7 inverse.
//  Opcode=12 -> illegal_op pulse in DECODE, FETCH next cycle, no RegWrite/MemWrite.
//  mem_ready=0 for 16 cycles in FETCH -> bus_error=1 after 15 waits, FETCH re-entered; reset clears.

Source files
------------

// File: rtl/mini_mips_pkg.sv
// Shared definitions for the MiniMips multi-cycle controller: opcodes, ALUop codes,
// mux select codes, FSM state encoding and the bundled control word.
package mini_mips_pkg;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_ANDI  = 4'd2;
  localparam logic [3:0] OP_ORI   = 4'd3;
  localparam logic [3:0] OP_LW    = 4'd4;
  localparam logic [3:0] OP_SW    = 4'd5;
  localparam logic [3:0] OP_BEQ   = 4'd6;
  localparam logic [3:0] OP_BNE   = 4'd7;
  localparam logic [3:0] OP_J     = 4'd8;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_AND   = 3'b010;
  localparam logic [2:0] ALUOP_OR    = 3'b011;
  localparam logic [2:0] ALUOP_RTYPE = 3'b111;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIFT = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_WB_R,
    ST_EXEC_I,
    ST_WB_I,
    ST_MEM_ADDR,
    ST_MEM_RD,
    ST_MEM_WB,
    ST_MEM_WR,
    ST_BRANCH,
    ST_JUMP
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       i_or_d;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
  } ctrl_t;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_J;
  endfunction

  function automatic logic [2:0] imm_alu_op(input logic [3:0] op);
    logic [2:0] aop;
    aop = ALUOP_ADD;
    case (op)
      OP_ANDI: aop = ALUOP_AND;
      OP_ORI:  aop = ALUOP_OR;
      default: aop = ALUOP_ADD;
    endcase
    return aop;
  endfunction

endpackage

// File: rtl/mini_mips_mem_watchdog.sv
// Memory wait-cycle counter: counts stalled request cycles, raises a one-cycle
// timeout when the limit is reached and keeps a sticky bus_error until reset.
module mini_mips_mem_watchdog
  import mini_mips_pkg::*;
#(
  parameter int MEM_TMO = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_req,
  input  logic mem_ready,
  input  logic state_change,
  output logic timeout,
  output logic bus_error
);

  localparam int CNT_W = $clog2(MEM_TMO + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TMO);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_error_q, bus_error_d;

  always_comb begin
    timeout = mem_req && (cnt_q == CNT_MAX);
    cnt_d   = cnt_q;
    if (timeout || state_change || (mem_req && mem_ready)) begin
      cnt_d = '0;
    end else if (mem_req && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    bus_error_d = bus_error_q | timeout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      bus_error_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign bus_error = bus_error_q;

endmodule

// File: rtl/mini_mips_main_control.sv
// Multi-cycle MiniMips main control FSM: fetch/decode/execute/memory/writeback
// sequencing, datapath enables and ALUop, with a memory-timeout watchdog.
//
//   state       | meaning
//   ST_FETCH    | read instruction at PC, PC+1 into PC when memory is ready
//   ST_DECODE   | compute branch target, dispatch on opcode
//   ST_EXEC_R   | R-type ALU operation (func field decides)
//   ST_WB_R     | write ALUOut to rd
//   ST_EXEC_I   | immediate ALU operation (add/and/or)
//   ST_WB_I     | write ALUOut to rt
//   ST_MEM_ADDR | compute load/store address
//   ST_MEM_RD   | data read, stall until ready
//   ST_MEM_WB   | write loaded data to rt
//   ST_MEM_WR   | data write, stall until ready
//   ST_BRANCH   | compare registers, load target if condition holds
//   ST_JUMP     | load jump target
module mini_mips_main_control
  import mini_mips_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int MEM_TMO  = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                Zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                IorD,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                RegWrite,
  output logic                RegDst,
  output logic                MemtoReg,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSource,
  output logic                ALUop2,
  output logic                ALUop1,
  output logic                ALUop0,
  output logic                illegal_op,
  output logic                bus_error
);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic                req_raw, ready_eff, timeout, state_change, bus_error_q;
  logic                illegal;
  ctrl_t               ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Opcode is captured once in DECODE so later IR changes cannot disturb execution.
  always_comb begin
    op_d      = (state_q == ST_DECODE) ? Opcode : op_q;
    req_raw   = state_q inside {ST_FETCH, ST_MEM_RD, ST_MEM_WR};
    ready_eff = req_raw && mem_ready && !timeout;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (timeout)        state_d = ST_FETCH;
        else if (ready_eff) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (Opcode)
          OP_RTYPE:                 state_d = ST_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = ST_EXEC_I;
          OP_LW, OP_SW:             state_d = ST_MEM_ADDR;
          OP_BEQ, OP_BNE:           state_d = ST_BRANCH;
          OP_J:                     state_d = ST_JUMP;
          default:                  state_d = ST_FETCH;
        endcase
      end
      ST_EXEC_R:   state_d = ST_WB_R;
      ST_WB_R:     state_d = ST_FETCH;
      ST_EXEC_I:   state_d = ST_WB_I;
      ST_WB_I:     state_d = ST_FETCH;
      ST_MEM_ADDR: state_d = (op_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD: begin
        if (timeout)        state_d = ST_FETCH;
        else if (ready_eff) state_d = ST_MEM_WB;
      end
      ST_MEM_WB:   state_d = ST_FETCH;
      ST_MEM_WR: begin
        if (timeout || ready_eff) state_d = ST_FETCH;
      end
      ST_BRANCH:   state_d = ST_FETCH;
      ST_JUMP:     state_d = ST_FETCH;
      default:     state_d = ST_FETCH;
    endcase
    state_change = (state_d != state_q) || timeout;
  end

  mini_mips_mem_watchdog #(
    .MEM_TMO(MEM_TMO)
  ) u_watchdog (
    .clk          (clk),
    .reset        (reset),
    .mem_req      (req_raw),
    .mem_ready    (mem_ready),
    .state_change (state_change),
    .timeout      (timeout),
    .bus_error    (bus_error_q)
  );

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_ONE;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = ready_eff;
        ctrl.pc_write  = ready_eff;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRCB_SHIFT;
        ctrl.alu_op    = ALUOP_ADD;
        illegal        = !op_legal(Opcode);
      end
      ST_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      ST_WB_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = imm_alu_op(op_q);
      end
      ST_WB_I: ctrl.reg_write = 1'b1;
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEM_RD: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_source = PCSRC_ALUOUT;
        // PCWriteCond already carries the resolved condition, so bne folds in !Zero here.
        ctrl.pc_write_cond = (op_q == OP_BNE) ? !Zero : Zero;
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
    if (timeout) ctrl = '0;
    if (reset) begin
      ctrl    = '0;
      illegal = 1'b0;
    end
  end

  assign mem_req     = ctrl.mem_req;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign IorD        = ctrl.i_or_d;
  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSource    = ctrl.pc_source;
  assign ALUop2      = ctrl.alu_op[2];
  assign ALUop1      = ctrl.alu_op[1];
  assign ALUop0      = ctrl.alu_op[0];
  assign illegal_op  = illegal;
  assign bus_error   = bus_error_q && !reset;

endmodule

// File: tb/tb_mini_mips_main_control.sv
// Scoreboard bench for the MiniMips main control FSM: stimulus queues the expected
// control word for each cycle, a negedge monitor pops and compares.
module tb_mini_mips_main_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] Opcode = 4'd0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, MemRead, MemWrite, IRWrite, IorD, PCWrite, PCWriteCond;
  logic       RegWrite, RegDst, MemtoReg, ALUSrcA, ALUop2, ALUop1, ALUop0;
  logic       illegal_op, bus_error;
  logic [1:0] ALUSrcB, PCSource;

  always #5 clk = ~clk;

  mini_mips_main_control #(.OPCODE_W(4), .MEM_TMO(15)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .IorD(IorD), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALUop2(ALUop2), .ALUop1(ALUop1), .ALUop0(ALUop0),
    .illegal_op(illegal_op), .bus_error(bus_error)
  );

  // {req,rd,wr,irw,iord,pcw,pcwc,rw,rdst,m2r,srca,srcb[2],pcsrc[2],aluop[3],ill,berr}
  function automatic logic [19:0] mk(
    input logic req, rd, wr, irw, iord, pcw, pcwc, rw, rdst, m2r, srca,
    input logic [1:0] srcb, pcsrc, input logic [2:0] aop, input logic ill, berr);
    return {req, rd, wr, irw, iord, pcw, pcwc, rw, rdst, m2r, srca, srcb, pcsrc, aop, ill, berr};
  endfunction

  logic [19:0] act;
  assign act = {mem_req, MemRead, MemWrite, IRWrite, IorD, PCWrite, PCWriteCond, RegWrite,
                RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUop2, ALUop1, ALUop0,
                illegal_op, bus_error};

  logic [19:0] exp_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [19:0] mon_exp;
  string       mon_name;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      n_cmp++;
      if (act !== mon_exp) begin
        n_err++;
        $display("FAIL %s: got %b expected %b", mon_name, act, mon_exp);
      end
    end
  end

  task automatic cyc(input logic [3:0] op, input logic z, input logic rdy, input logic rst,
                     input logic [19:0] e, input string nm);
    @(posedge clk);
    #1;
    Opcode    = op;
    Zero      = z;
    mem_ready = rdy;
    reset     = rst;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  logic [19:0] ZV, F_WAIT, F_RDY, DEC, DEC_ILL, EXR, WBR, EXI_ADD, EXI_AND, EXI_OR;
  logic [19:0] WBI, MRD, MWB, MWR, BR_T, BR_N, JMP;

  initial begin
    ZV      = '0;
    F_WAIT  = mk(1,1,0,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b000, 0, 0);
    F_RDY   = mk(1,1,0,1,0,1,0,0,0,0,0, 2'b01, 2'b00, 3'b000, 0, 0);
    DEC     = mk(0,0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b000, 0, 0);
    DEC_ILL = mk(0,0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b000, 1, 0);
    EXR     = mk(0,0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b111, 0, 0);
    WBR     = mk(0,0,0,0,0,0,0,1,1,0,0, 2'b00, 2'b00, 3'b000, 0, 0);
    EXI_ADD = mk(0,0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b000, 0, 0);
    EXI_AND = mk(0,0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0, 0);
    EXI_OR  = mk(0,0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b011, 0, 0);
    WBI     = mk(0,0,0,0,0,0,0,1,0,0,0, 2'b00, 2'b00, 3'b000, 0, 0);
    MRD     = mk(1,1,0,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0, 0);
    MWB     = mk(0,0,0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 3'b000, 0, 0);
    MWR     = mk(1,0,1,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0, 0);
    BR_T    = mk(0,0,0,0,0,0,1,0,0,0,1, 2'b00, 2'b01, 3'b001, 0, 0);
    BR_N    = mk(0,0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b001, 0, 0);
    JMP     = mk(0,0,0,0,0,1,0,0,0,0,0, 2'b00, 2'b10, 3'b000, 0, 0);

    cyc(0, 0, 0, 1, ZV, "reset_cycle0");
    cyc(0, 0, 1, 1, ZV, "reset_cycle1");

    // R-type: 4 cycles, then FETCH
    cyc(0, 0, 1, 0, F_RDY, "r_fetch");
    cyc(0, 0, 1, 0, DEC,   "r_decode");
    cyc(0, 0, 1, 0, EXR,   "r_exec");
    cyc(0, 0, 1, 0, WBR,   "r_wb");

    // immediates; Opcode disturbed after DECODE must not matter
    cyc(1, 0, 1, 0, F_RDY,   "addi_fetch");
    cyc(1, 0, 1, 0, DEC,     "addi_decode");
    cyc(4, 0, 1, 0, EXI_ADD, "addi_exec");
    cyc(4, 0, 1, 0, WBI,     "addi_wb");
    cyc(2, 0, 1, 0, F_RDY,   "andi_fetch");
    cyc(2, 0, 1, 0, DEC,     "andi_decode");
    cyc(2, 0, 1, 0, EXI_AND, "andi_exec");
    cyc(2, 0, 1, 0, WBI,     "andi_wb");
    cyc(3, 0, 1, 0, F_RDY,   "ori_fetch");
    cyc(3, 0, 1, 0, DEC,     "ori_decode");
    cyc(0, 0, 1, 0, EXI_OR,  "ori_exec");
    cyc(0, 0, 1, 0, WBI,     "ori_wb");

    // lw with memory stalled three cycles in MEM_RD
    cyc(4, 0, 1, 0, F_RDY, "lw_fetch");
    cyc(4, 0, 1, 0, DEC,   "lw_decode");
    cyc(4, 0, 1, 0, EXI_ADD, "lw_addr");
    cyc(4, 0, 0, 0, MRD,   "lw_stall1");
    cyc(4, 0, 0, 0, MRD,   "lw_stall2");
    cyc(4, 0, 0, 0, MRD,   "lw_stall3");
    cyc(4, 0, 1, 0, MRD,   "lw_ready");
    cyc(4, 0, 1, 0, MWB,   "lw_wb");

    // sw
    cyc(5, 0, 1, 0, F_RDY,   "sw_fetch");
    cyc(5, 0, 1, 0, DEC,     "sw_decode");
    cyc(5, 0, 1, 0, EXI_ADD, "sw_addr");
    cyc(5, 0, 1, 0, MWR,     "sw_write");

    // branches
    cyc(6, 1, 1, 0, F_RDY, "beq_z1_fetch");
    cyc(6, 1, 1, 0, DEC,   "beq_z1_decode");
    cyc(6, 1, 1, 0, BR_T,  "beq_z1_taken");
    cyc(6, 0, 1, 0, F_RDY, "beq_z0_fetch");
    cyc(6, 0, 1, 0, DEC,   "beq_z0_decode");
    cyc(6, 0, 1, 0, BR_N,  "beq_z0_not_taken");
    cyc(7, 1, 1, 0, F_RDY, "bne_z1_fetch");
    cyc(7, 1, 1, 0, DEC,   "bne_z1_decode");
    cyc(7, 1, 1, 0, BR_N,  "bne_z1_not_taken");
    cyc(7, 0, 1, 0, F_RDY, "bne_z0_fetch");
    cyc(7, 0, 1, 0, DEC,   "bne_z0_decode");
    cyc(7, 0, 1, 0, BR_T,  "bne_z0_taken");

    // jump
    cyc(8, 0, 1, 0, F_RDY, "j_fetch");
    cyc(8, 0, 1, 0, DEC,   "j_decode");
    cyc(8, 0, 1, 0, JMP,   "j_jump");

    // illegal opcode
    cyc(12, 0, 1, 0, F_RDY,   "ill_fetch");
    cyc(12, 0, 1, 0, DEC_ILL, "ill_decode");

    // FETCH timeout: 15 waits, request dropped on the 16th, then sticky bus_error
    for (int i = 1; i <= 15; i++) cyc(0, 0, 0, 0, F_WAIT, $sformatf("tmo_wait%0d", i));
    cyc(0, 0, 1, 0, ZV, "tmo_drop");
    cyc(0, 0, 0, 0, F_WAIT | 20'd1, "berr_set");
    cyc(0, 0, 1, 0, F_RDY | 20'd1,  "berr_sticky");
    cyc(0, 0, 0, 1, ZV,             "berr_reset");
    cyc(0, 0, 0, 0, F_WAIT,         "berr_cleared");

    // reset in the middle of a load
    cyc(4, 0, 1, 0, F_RDY,   "mid_fetch");
    cyc(4, 0, 1, 0, DEC,     "mid_decode");
    cyc(4, 0, 1, 0, EXI_ADD, "mid_addr");
    cyc(4, 0, 1, 1, ZV,      "mid_reset");
    cyc(4, 0, 0, 0, F_WAIT,  "mid_refetch");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL time_limit: got still running expected finished");
    $fatal(1, "time limit");
  end

endmodule
